// File: rtl/param_bus_datapath.sv
// Parametrised single-bus datapath: register file, Y/Z staging, HI/LO, ALU and a
// T3-T4-T5 sequencer that runs one R[ra] <= R[rb] op R[rc] instruction per start.
module param_bus_datapath #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int R0_ZERO  = 0,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [IDX_W-1:0]  ra,
   input  logic [IDX_W-1:0]  rb,
   input  logic [IDX_W-1:0]  rc,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_idx,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] bus_out,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done,
   output logic              op_err
);

   localparam int SH_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, T3, T4, T5} state_t;

   state_t              state, state_nxt;
   logic [3:0]          op_q;
   logic [IDX_W-1:0]    ra_q, rb_q, rc_q;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [DATA_W-1:0]   y;
   logic [2*DATA_W-1:0] z, alu_z;

   logic                accept, reserved, muldiv, gpr_wr;
   logic [IDX_W-1:0]    src_idx;
   logic [DATA_W-1:0]   src_val;
   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;
   logic [DATA_W-1:0]   wr_data;

   // A start seen on the T5 exit edge chains straight into the next T3.
   assign accept   = start && (state == IDLE || state == T5);
   assign reserved = (op_q >= 4'd13);
   assign muldiv   = (op_q == 4'd9) || (op_q == 4'd10);
   assign gpr_wr   = !reserved && !muldiv;
   assign busy     = (state != IDLE);

   assign src_idx = (state == T4) ? rc_q : rb_q;
   assign src_val = (R0_ZERO != 0 && src_idx == '0) ? '0 : regs[src_idx];
   assign rd_data = (R0_ZERO != 0 && rd_idx == '0) ? '0 : regs[rd_idx];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = T3;
         T3:      state_nxt = T4;
         T4:      state_nxt = T5;
         T5:      state_nxt = start ? T3 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      case (state)
         T3, T4:  bus_out = src_val;
         T5:      bus_out = z[DATA_W-1:0];
         default: bus_out = '0;
      endcase
   end

   // Single write port shared by the host loader (IDLE) and T5 writeback.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = ld_idx;
      wr_data = ld_data;
      if (state == IDLE && ld_en) begin
         wr_en = 1'b1;
      end else if (state == T5 && gpr_wr) begin
         wr_en   = 1'b1;
         wr_idx  = ra_q;
         wr_data = z[DATA_W-1:0];
      end
      if (R0_ZERO != 0 && wr_idx == '0) wr_en = 1'b0;
   end

   // ALU: A is the Y staging register, B is the value on the bus during T4.
   logic [DATA_W-1:0]          a, b, b_safe;
   logic [SH_W-1:0]            amt, rot;
   logic [SH_W:0]              rot_c;
   logic signed [DATA_W-1:0]   sra, quot, rem;
   logic [2*DATA_W-1:0]        a_ext, b_ext, prod;
   logic                       b_zero, div_ovf;

   always_comb begin
      a       = y;
      b       = bus_out;
      amt     = b[SH_W-1:0];
      rot     = (amt >= SH_W'(DATA_W)) ? amt - SH_W'(DATA_W) : amt;
      rot_c   = (SH_W+1)'(DATA_W) - {1'b0, rot};
      sra     = $signed(a) >>> amt;
      a_ext   = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext   = {{DATA_W{b[DATA_W-1]}}, b};
      prod    = a_ext * b_ext;
      b_zero  = (b == '0);
      div_ovf = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
      // Keep the divider away from /0 and the overflow case; those are muxed below.
      b_safe  = (b_zero || div_ovf) ? DATA_W'(1) : b;
      quot    = $signed(a) / $signed(b_safe);
      rem     = $signed(a) % $signed(b_safe);

      alu_z = '0;
      case (op_q)
         4'd0:  alu_z[DATA_W-1:0] = a + b;
         4'd1:  alu_z[DATA_W-1:0] = a - b;
         4'd2:  alu_z[DATA_W-1:0] = a & b;
         4'd3:  alu_z[DATA_W-1:0] = a | b;
         4'd4:  alu_z[DATA_W-1:0] = a >> amt;
         4'd5:  alu_z[DATA_W-1:0] = sra;
         4'd6:  alu_z[DATA_W-1:0] = a << amt;
         4'd7:  alu_z[DATA_W-1:0] = (a >> rot) | (a << rot_c);
         4'd8:  alu_z[DATA_W-1:0] = (a << rot) | (a >> rot_c);
         4'd9:  alu_z = prod;
         4'd10: begin
            if (b_zero)       alu_z = {a, {DATA_W{1'b1}}};
            else if (div_ovf) alu_z = {{DATA_W{1'b0}}, a};
            else              alu_z = {rem, quot};
         end
         4'd11: alu_z[DATA_W-1:0] = -a;
         4'd12: alu_z[DATA_W-1:0] = ~a;
         default: alu_z = '0;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the register file is cleared on reset so no stale or partial writeback survives clr.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         op_q   <= '0;
         ra_q   <= '0;
         rb_q   <= '0;
         rc_q   <= '0;
         y      <= '0;
         z      <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         op_err <= 1'b0;
      end else begin
         done   <= (state == T5);
         op_err <= (state == T5) && reserved;
         if (accept) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
         end
         if (state == T3) y <= bus_out;
         if (state == T4) z <= alu_z;
         if (state == T5 && muldiv) begin
            hi <= z[2*DATA_W-1:DATA_W];
            lo <= z[DATA_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed bench for param_bus_datapath: a default build and an R0_ZERO=1 build share
// the same stimulus; expected values are hand-computed constants.
module tb_param_bus_datapath;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int IDX_W    = 4;

   logic              clk = 1'b0;
   logic              clr;
   logic              start;
   logic [3:0]        op;
   logic [IDX_W-1:0]  ra, rb, rc;
   logic              ld_en;
   logic [IDX_W-1:0]  ld_idx;
   logic [DATA_W-1:0] ld_data;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_data, bus_out, hi, lo;
   logic              busy, done, op_err;
   logic [DATA_W-1:0] rd_data_z, bus_out_z, hi_z, lo_z;
   logic              busy_z, done_z, op_err_z;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   param_bus_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .R0_ZERO(0)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .rd_idx(rd_idx),
      .rd_data(rd_data), .bus_out(bus_out), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .op_err(op_err)
   );

   param_bus_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .R0_ZERO(1)) dut_z (
      .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .rd_idx(rd_idx),
      .rd_data(rd_data_z), .bus_out(bus_out_z), .hi(hi_z), .lo(lo_z),
      .busy(busy_z), .done(done_z), .op_err(op_err_z)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_load(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
      ld_en   = 1'b1;
      ld_idx  = idx;
      ld_data = data;
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [IDX_W-1:0] idx,
                             input logic [DATA_W-1:0] exp);
      rd_idx = idx;
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic read_check_z(input string tag, input logic [IDX_W-1:0] idx,
                               input logic [DATA_W-1:0] exp);
      rd_idx = idx;
      #1;
      check(tag, rd_data_z, exp);
   endtask

   // Issues one instruction and checks done latency, busy length and op_err on both builds.
   task automatic run_op(input string tag, input logic [3:0] code, input logic [IDX_W-1:0] dst,
                         input logic [IDX_W-1:0] src1, input logic [IDX_W-1:0] src2,
                         input logic exp_err);
      int  busy_cnt;
      bit  got;
      op    = code;
      ra    = dst;
      rb    = src1;
      rc    = src2;
      start = 1'b1;
      tick();
      start    = 1'b0;
      ld_en    = 1'b0;
      busy_cnt = 0;
      got      = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
         if (n > 0) tick();
         if (busy) busy_cnt++;
         if (done) begin
            got = 1'b1;
            check({tag, " latency"}, 64'(n), 64'd3);
            check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd3);
            check({tag, " op_err"}, {63'd0, op_err}, {63'd0, exp_err});
            check({tag, " done_z"}, {63'd0, done_z}, 64'd1);
         end
      end
      if (!got) check({tag, " timeout"}, 64'd0, 64'd1);
   endtask

   typedef struct {
      string             name;
      logic [3:0]        code;
      logic [DATA_W-1:0] exp;
   } alu_vec_t;

   alu_vec_t shift_vecs[10] = '{
      '{"shr",  4'd4,  32'h4000_0000},
      '{"shra", 4'd5,  32'hC000_0000},
      '{"ror",  4'd7,  32'hC000_0000},
      '{"rol",  4'd8,  32'h0000_0003},
      '{"shl",  4'd6,  32'h0000_0002},
      '{"sub",  4'd1,  32'h7FFF_FFE0},
      '{"and",  4'd2,  32'h0000_0001},
      '{"or",   4'd3,  32'h8000_0021},
      '{"neg",  4'd11, 32'h7FFF_FFFF},
      '{"not",  4'd12, 32'h7FFF_FFFE}
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_done;

      clr = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
      ld_en = 1'b0; ld_idx = '0; ld_data = '0; rd_idx = '0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;

      check("rst busy", {63'd0, busy}, 64'd0);
      check("rst done", {63'd0, done}, 64'd0);
      check("rst op_err", {63'd0, op_err}, 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      check("rst bus_out", 64'(bus_out), 64'd0);
      read_check("rst r5", 4'd5, 32'd0);

      // Reset in the middle of an ADD.
      host_load(4'd1, 32'd5);
      host_load(4'd2, 32'd7);
      op = 4'd0; ra = 4'd3; rb = 4'd1; rc = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      check("t3 bus", 64'(bus_out), 64'd5);
      tick();
      check("t4 bus", 64'(bus_out), 64'd7);
      clr = 1'b1;
      #1;
      check("midrst busy", {63'd0, busy}, 64'd0);
      check("midrst done", {63'd0, done}, 64'd0);
      check("midrst bus", 64'(bus_out), 64'd0);
      tick();
      clr = 1'b0;
      seen_done = 1'b0;
      repeat (4) begin
         tick();
         seen_done |= done;
      end
      check("midrst no done", {63'd0, seen_done}, 64'd0);
      read_check("midrst r1", 4'd1, 32'd0);
      read_check("midrst r2", 4'd2, 32'd0);
      read_check("midrst r3", 4'd3, 32'd0);

      // ADD with wrap.
      host_load(4'd1, 32'hFFFF_FFFF);
      host_load(4'd2, 32'd2);
      run_op("add", 4'd0, 4'd3, 4'd1, 4'd2, 1'b0);
      read_check("add r3", 4'd3, 32'h0000_0001);

      // MUL / DIV into HI/LO, no GPR write.
      host_load(4'd4, 32'hFFFF_FFFA);
      host_load(4'd5, 32'd4);
      run_op("mul", 4'd9, 4'd6, 4'd4, 4'd5, 1'b0);
      check("mul hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check("mul lo", 64'(lo), 64'h0000_0000_FFFF_FFE8);
      read_check("mul no gpr", 4'd6, 32'd0);
      run_op("div", 4'd10, 4'd6, 4'd4, 4'd5, 1'b0);
      check("div lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
      check("div hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      run_op("div0", 4'd10, 4'd6, 4'd4, 4'd0, 1'b0);
      check("div0 lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
      check("div0 hi", 64'(hi), 64'h0000_0000_FFFF_FFFA);
      host_load(4'd8, 32'h8000_0000);
      host_load(4'd9, 32'hFFFF_FFFF);
      run_op("divovf", 4'd10, 4'd6, 4'd8, 4'd9, 1'b0);
      check("divovf lo", 64'(lo), 64'h0000_0000_8000_0000);
      check("divovf hi", 64'(hi), 64'd0);

      // Shifts, rotates and the remaining logic/arith ops: A=8000_0001, B=0x21 (amount 1).
      host_load(4'd6, 32'h8000_0001);
      host_load(4'd7, 32'h0000_0021);
      foreach (shift_vecs[i]) begin
         run_op(shift_vecs[i].name, shift_vecs[i].code, 4'd8, 4'd6, 4'd7, 1'b0);
         read_check({shift_vecs[i].name, " r8"}, 4'd8, shift_vecs[i].exp);
      end

      // Full aliasing: sources read before writeback.
      host_load(4'd10, 32'd3);
      run_op("alias", 4'd0, 4'd10, 4'd10, 4'd10, 1'b0);
      read_check("alias r10", 4'd10, 32'd6);

      // Back-to-back with start held, a dropped load, and a reserved op last.
      op = 4'd0; ra = 4'd11; rb = 4'd1; rc = 4'd2; start = 1'b1;
      tick();
      op = 4'd1; ra = 4'd12; rb = 4'd11; rc = 4'd2;
      ld_en = 1'b1; ld_idx = 4'd7; ld_data = 32'hDEAD_BEEF;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         tick();
         ld_en = 1'b0;
         check($sformatf("b2b done c%0d", cyc), {63'd0, done}, {63'd0, (cyc % 3 == 0)});
         check($sformatf("b2b op_err c%0d", cyc), {63'd0, op_err}, {63'd0, (cyc == 9)});
         if (cyc == 3) begin
            op = 4'd14; ra = 4'd13; rb = 4'd1; rc = 4'd2;
         end
         if (cyc == 6) start = 1'b0;
      end
      check("b2b idle", {63'd0, busy}, 64'd0);
      read_check("b2b r11", 4'd11, 32'h0000_0001);
      read_check("b2b r12", 4'd12, 32'hFFFF_FFFF);
      read_check("b2b r13 reserved", 4'd13, 32'd0);
      read_check("b2b dropped load r7", 4'd7, 32'h0000_0021);

      // Load and start on the same edge: T3 sees the freshly loaded value.
      ld_en = 1'b1; ld_idx = 4'd14; ld_data = 32'd100;
      run_op("ldstart", 4'd0, 4'd15, 4'd14, 4'd14, 1'b0);
      read_check("ldstart r15", 4'd15, 32'd200);

      // R0 behaviour: default build writes R0, R0_ZERO build discards it.
      host_load(4'd1, 32'd9);
      run_op("r0 wr", 4'd0, 4'd0, 4'd1, 4'd1, 1'b0);
      read_check("r0 plain", 4'd0, 32'd18);
      read_check_z("r0 zero", 4'd0, 32'd0);
      run_op("r0 rd", 4'd0, 4'd2, 4'd0, 4'd1, 1'b0);
      read_check("r0 plain r2", 4'd2, 32'd27);
      read_check_z("r0 zero r2", 4'd2, 32'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
